cl_logic_unit: RTL and testbench

- Registered bitwise logic unit that applies one of four logic operations to operands a and b, selected by a 2-bit code s.
- Serves as the logic slice beside the adder and half-adder blocks in the datapath ALU.
- Single clock domain; one-cycle latency with a valid strobe.

---
 rtl/cl_pkg.sv | 12 +
 rtl/cl_core.sv | 24 ++
 rtl/cl_logic_unit.sv | 59 +++++
 tb/tb_cl_logic_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cl_pkg.sv
// Shared definitions for the cl_logic_unit logic slice: operation select
// encoding and its type.
package cl_pkg;

  typedef logic [1:0] op_sel_t;

  localparam op_sel_t OP_AND = 2'b00;
  localparam op_sel_t OP_OR  = 2'b01;
  localparam op_sel_t OP_XOR = 2'b10;
  localparam op_sel_t OP_NOT = 2'b11;

endpackage

// File: rtl/cl_core.sv
// Combinational four-way bitwise mux behind cl_logic_unit; each result bit
// depends only on the matching bits of a and b, with no carries.
module cl_core
  import cl_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_sel_t          s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (s)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~a;
    endcase
  end

endmodule

// File: rtl/cl_logic_unit.sv
// Registered bitwise logic unit with a one-cycle valid strobe and a zero flag.
// Define CL_PARITY_EN to add a registered parity output alongside zero.
module cl_logic_unit
  import cl_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_sel_t          s,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
`ifdef CL_PARITY_EN
  output logic             parity,
`endif
  output logic             zero
);

  logic [WIDTH-1:0] core_y;

  cl_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a(a),
    .b(b),
    .s(s),
    .y(core_y)
  );

  // Result and flags load only on in_valid, so a floating select while idle
  // can never reach the stored state; reset wins over a same-cycle operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= core_y;
        zero <= ~|core_y;
      end
    end
  end

`ifdef CL_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (in_valid) begin
      parity <= ^core_y;
    end
  end
`endif

endmodule

// File: tb/tb_cl_logic_unit.sv
// Scoreboard bench for cl_logic_unit: an 8-bit and a 1-bit instance share the
// same stimulus stream and are checked against a per-bit arithmetic model.
module tb_cl_logic_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [1:0] s = '0;

  logic [7:0] out8;
  logic       out_valid8;
  logic       zero8;
  logic [0:0] a1;
  logic [0:0] b1;
  logic [0:0] out1;
  logic       out_valid1;
  logic       zero1;
`ifdef CL_PARITY_EN
  logic       parity8;
  logic       parity1;
`endif

  assign a1 = a[0];
  assign b1 = b[0];

  always #5 clk = ~clk;

  cl_logic_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .s(s),
    .out(out8),
    .out_valid(out_valid8),
`ifdef CL_PARITY_EN
    .parity(parity8),
`endif
    .zero(zero8)
  );

  cl_logic_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .a(a1),
    .b(b1),
    .s(s),
    .out(out1),
    .out_valid(out_valid1),
`ifdef CL_PARITY_EN
    .parity(parity1),
`endif
    .zero(zero1)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  // Per-bit reference using 0/1 arithmetic rather than logic operators.
  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] op);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      int ai, bi, r;
      ai = x[i] ? 1 : 0;
      bi = y[i] ? 1 : 0;
      case (op)
        2'd0:    r = ai * bi;
        2'd1:    r = ai + bi - ai * bi;
        2'd2:    r = (ai + bi) % 2;
        default: r = 1 - ai;
      endcase
      res[i] = (r == 1);
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rst, input logic [7:0] av,
                               input logic [7:0] bv, input logic [1:0] sv);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    a        = av;
    b        = bv;
    s        = v ? sv : 2'bxx;
    if (v && !rst) exp_q.push_back(ref_op(av, bv, sv));
  endtask

  // Monitor: held model state is what out/zero/parity must show whenever no
  // fresh result is presented.
  logic       samp_rst;
  logic [7:0] held = '0;
  logic       held_zero8 = 1'b0;
  logic       held_zero1 = 1'b0;
  logic       held_par8 = 1'b0;
  logic       held_par1 = 1'b0;
  logic       exp_valid;

  always @(posedge clk) begin
    samp_rst = reset;
    #1;
    exp_valid = 1'b0;
    if (samp_rst) begin
      held = '0; held_zero8 = 1'b0; held_zero1 = 1'b0;
      held_par8 = 1'b0; held_par1 = 1'b0;
    end else if (out_valid8 || exp_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", {7'd0, out_valid8}, 8'd0);
      end else begin
        held = exp_q.pop_front();
        exp_valid  = 1'b1;
        held_zero8 = (held == 8'd0);
        held_zero1 = (held[0] == 1'b0);
        held_par8  = ^held;
        held_par1  = held[0];
      end
    end
    checkOutput("out_valid8", {7'd0, out_valid8}, {7'd0, exp_valid});
    checkOutput("out8", out8, held);
    checkOutput("zero8", {7'd0, zero8}, {7'd0, held_zero8});
    checkOutput("out_valid1", {7'd0, out_valid1}, {7'd0, exp_valid});
    checkOutput("out1", {7'd0, out1}, {7'd0, held[0]});
    checkOutput("zero1", {7'd0, zero1}, {7'd0, held_zero1});
`ifdef CL_PARITY_EN
    checkOutput("parity8", {7'd0, parity8}, {7'd0, held_par8});
    checkOutput("parity1", {7'd0, parity1}, {7'd0, held_par1});
`endif
  end

  initial begin
    // Reset held for two cycles while a valid operation is presented.
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h01, 2'b00);
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h01, 2'b00);

    // Truth table on bit 0, one vector every 20 ns.
    for (int op = 0; op < 4; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic [1:0] abv;
        abv = ab[1:0];
        applyStimulus(1'b1, 1'b0, {7'd0, abv[0]}, {7'd0, abv[1]}, op[1:0]);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
      end
    end

    // Full-width patterns, back to back.
    for (int op = 0; op < 4; op++) applyStimulus(1'b1, 1'b0, 8'hF0, 8'h3C, op[1:0]);

    // Zero result then three idle cycles of hold.
    applyStimulus(1'b1, 1'b0, 8'hAA, 8'h55, 2'b00);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'hFF, 8'hFF, 2'b11);

    // Reset lands on the third of a back-to-back burst.
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h34, 2'b01);
    applyStimulus(1'b1, 1'b0, 8'h56, 8'h78, 2'b10);
    applyStimulus(1'b1, 1'b1, 8'h9A, 8'hBC, 2'b11);
    applyStimulus(1'b1, 1'b0, 8'hC3, 8'h0F, 2'b10);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);

    // Parity pattern (odd then even population).
    applyStimulus(1'b1, 1'b0, 8'h07, 8'h00, 2'b01);
    applyStimulus(1'b1, 1'b0, 8'h03, 8'h00, 2'b01);

    // Randomized traffic with idle gaps and sporadic reset.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                    8'($urandom), 8'($urandom), 2'($urandom));
    end

    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    @(negedge clk);
    checkOutput("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
